idex_stage: RTL and testbench
=============================

// Module: idex_stage
// PURPOSE
//  ID/EX pipeline register and operand-select stage directly upstream of alu.
//  - Latches decoded operands, ALU op and destination info each cycle.
//  - Resolves EX/MEM and MEM/WB forwarding, and the imm-vs-rs2 choice.
//  - Drives alu a/b/op combinationally from its registered state.
//  - Detects load-use hazards and inserts one bubble.
// PARAMETERS
//  XLEN     32  datapath width (alu a/b/res width)
//  REG_IDXW 5   register index width
// PORTS
//  clk          in  1     clock, rising edge
//  rst          in  1     asynchronous, active-high reset
//  stall        in  1     hold all stage state (downstream back-pressure)
//  flush        in  1     kill the instruction entering EX (branch taken)
//  id_valid     in  1     decode presents an instruction
//  id_rs1       in  REG_IDXW  source reg 1 index
//  id_rs2       in  REG_IDXW  source reg 2 index
//  id_uses_rs2  in  1     instruction reads rs2 (hazard check only)
//  id_rs1_data  in  XLEN  register-file read 1
//  id_rs2_data  in  XLEN  register-file read 2
//  id_imm       in  XLEN  sign-extended immediate
//  id_use_imm   in  1     1: b = imm, 0: b = rs2 (after forwarding)
//  id_alu_op    in  4     ALU op code (package constants)
//  id_rd        in  REG_IDXW  destination index
//  id_reg_we    in  1     writes rd
//  id_mem_read  in  1     instruction is a load
//  mem_rd, mem_reg_we, mem_res  in  REG_IDXW/1/XLEN  EX/MEM forward source
//  wb_rd,  wb_reg_we,  wb_res   in  REG_IDXW/1/XLEN  MEM/WB forward source
//  id_ready     out 1     0: decode must hold its instruction this cycle
//  ex_valid     out 1     registered valid into EX
//  ex_a         out XLEN  alu operand a (forwarded)
//  ex_b         out XLEN  alu operand b (imm or forwarded rs2)
//  ex_op        out 4     alu op
//  ex_rd, ex_reg_we, ex_mem_read  out REG_IDXW/1/1  carried to EX/MEM
// BEHAVIOUR
//  - Reset (async): every register 0; ex_valid=0, ex_op=ALU_ADD(0), ex_rd=0.
//    id_ready is combinational and reads 1 out of reset.
//  - Hazard (comb): ex_valid & ex_mem_read & ex_rd!=0 &
//    (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)) & id_valid.
//  - id_ready = !stall & !hazard.
//  - Priority per clk edge: flush > stall > hazard > normal.
//    - flush: register loads a bubble (valid=0, reg_we=0, mem_read=0),
//      even when stall=1.
//    - stall: all registers hold.
//    - hazard: bubble loaded; decode holds. Exactly 1 bubble, since the load
//      then leaves EX.
//    - normal: capture all id_* fields; valid = id_valid.
//  - Forwarding, rs1 and rs2 independently, on registered indices:
//    - EX/MEM hit (mem_reg_we & mem_rd!=0 & mem_rd==rs) beats MEM/WB hit.
//    - No hit: use the registered regfile data.
//    - Index 0 is never forwarded.
//  - ex_b = registered use_imm ? imm : fwd_rs2. ex_a = fwd_rs1.
//  - Latency: 1 cycle ID->EX. The forward muxes are comb; alu res is valid
//    in the same cycle as ex_valid.
//  - Bubble with stale data: ex_a/ex_b may be nonzero. Consumers gate on
//    ex_valid/ex_reg_we.
//  - rst mid-stall or mid-hazard: returns to the reset state immediately;
//    no bubble is pending afterwards.
// STRUCTURE
//  - cpu_pkg holds:
//    - ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_XOR=4, ALU_SLL=5,
//      ALU_SRL=6.
//    - Flag indices N=3, Z=2, C=1, V=0.
//    - idex_t packed struct for the pipeline register.
//  - One sub-module: fwd_mux (rs idx, regdata, mem/wb sources -> operand),
//    instantiated twice.
// TESTING
//  1. rst=1 mid-run -> ex_valid=0, ex_op=0, ex_reg_we=0 immediately, with
//     no clock edge.
//  2. AND: rs1_data=FFFFFFFF, use_imm=1, imm=0, op=2 -> next cycle
//     ex_a=FFFFFFFF, ex_b=0; alu res=0, flags=0100.
//  3. mem_rd=5, mem_res=7FFFFFFF; wb_rd=5, wb_res=1; registered rs1=5 ->
//     ex_a=7FFFFFFF (EX/MEM wins). With rs1=0 -> ex_a=regfile data.
//  4. ex holds load rd=3; id rs1=3, id_valid=1 -> id_ready=0 for 1 cycle,
//     then ex_valid=0 bubble; next cycle instruction captured and
//     id_ready=1.
//  5. stall=1 for 3 cycles -> ex_* constant, id_ready=0. stall=1 & flush=1
//     together -> ex_valid=0 next cycle.
//  6. SLL: rs1=0000000F, rs2=31 via MEM/WB forward, op=5 -> alu res=80000000,
//     flags=1000.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, alu op codes, flag indices and the id/ex pipeline register layout
package cpu_pkg;
    localparam int XLEN = 32;
    localparam int REG_IDXW = 5;
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    typedef struct packed {
        logic                valid;
        logic [REG_IDXW-1:0] rs1;
        logic [REG_IDXW-1:0] rs2;
        logic [XLEN-1:0]     rs1_data;
        logic [XLEN-1:0]     rs2_data;
        logic [XLEN-1:0]     imm;
        logic                use_imm;
        logic [3:0]          alu_op;
        logic [REG_IDXW-1:0] rd;
        logic                reg_we;
        logic                mem_read;
    } idex_t;
    // Operand fields stay stale in a bubble; only the side-effect bits are cleared.
    function automatic idex_t to_bubble(idex_t x);
        idex_t b;
        b = x;
        b.valid = 1'b0;
        b.reg_we = 1'b0;
        b.mem_read = 1'b0;
        return b;
    endfunction
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: picks the newest value of one source register, EX/MEM before MEM/WB before regfile
module fwd_mux
    import cpu_pkg::*;
(
    input  logic [REG_IDXW-1:0] rs,
    input  logic [XLEN-1:0]     regdata,
    input  logic [REG_IDXW-1:0] mem_rd,
    input  logic                mem_reg_we,
    input  logic [XLEN-1:0]     mem_res,
    input  logic [REG_IDXW-1:0] wb_rd,
    input  logic                wb_reg_we,
    input  logic [XLEN-1:0]     wb_res,
    output logic [XLEN-1:0]     operand
);
    logic mem_hit, wb_hit;
    assign mem_hit = mem_reg_we && mem_rd != '0 && mem_rd == rs;
    assign wb_hit = wb_reg_we && wb_rd != '0 && wb_rd == rs;
    assign operand = mem_hit ? mem_res : wb_hit ? wb_res : regdata;
endmodule

// File: rtl/idex_stage.sv
// idex_stage: ID/EX pipeline register with forwarding, imm select and load-use bubble insertion
module idex_stage
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                id_valid,
    input  logic [REG_IDXW-1:0] id_rs1,
    input  logic [REG_IDXW-1:0] id_rs2,
    input  logic                id_uses_rs2,
    input  logic [XLEN-1:0]     id_rs1_data,
    input  logic [XLEN-1:0]     id_rs2_data,
    input  logic [XLEN-1:0]     id_imm,
    input  logic                id_use_imm,
    input  logic [3:0]          id_alu_op,
    input  logic [REG_IDXW-1:0] id_rd,
    input  logic                id_reg_we,
    input  logic                id_mem_read,
    input  logic [REG_IDXW-1:0] mem_rd,
    input  logic                mem_reg_we,
    input  logic [XLEN-1:0]     mem_res,
    input  logic [REG_IDXW-1:0] wb_rd,
    input  logic                wb_reg_we,
    input  logic [XLEN-1:0]     wb_res,
    output logic                id_ready,
    output logic                ex_valid,
    output logic [XLEN-1:0]     ex_a,
    output logic [XLEN-1:0]     ex_b,
    output logic [3:0]          ex_op,
    output logic [REG_IDXW-1:0] ex_rd,
    output logic                ex_reg_we,
    output logic                ex_mem_read
);
    idex_t r, cap;
    logic hazard;
    logic [XLEN-1:0] fwd_b;
    always_comb begin
        cap = '{valid: id_valid, rs1: id_rs1, rs2: id_rs2, rs1_data: id_rs1_data,
                rs2_data: id_rs2_data, imm: id_imm, use_imm: id_use_imm, alu_op: id_alu_op,
                rd: id_rd, reg_we: id_reg_we, mem_read: id_mem_read};
    end
    // A load in EX whose result the incoming instruction needs cannot be forwarded yet.
    assign hazard = id_valid && r.valid && r.mem_read && r.rd != '0 &&
                    (r.rd == id_rs1 || (id_uses_rs2 && r.rd == id_rs2));
    assign id_ready = !stall && !hazard;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r <= '0;
        else if (flush) r <= to_bubble(cap);
        else if (!stall) r <= hazard ? to_bubble(cap) : cap;
    end
    fwd_mux u_fwd_a (
        .rs(r.rs1), .regdata(r.rs1_data),
        .mem_rd(mem_rd), .mem_reg_we(mem_reg_we), .mem_res(mem_res),
        .wb_rd(wb_rd), .wb_reg_we(wb_reg_we), .wb_res(wb_res),
        .operand(ex_a)
    );
    fwd_mux u_fwd_b (
        .rs(r.rs2), .regdata(r.rs2_data),
        .mem_rd(mem_rd), .mem_reg_we(mem_reg_we), .mem_res(mem_res),
        .wb_rd(wb_rd), .wb_reg_we(wb_reg_we), .wb_res(wb_res),
        .operand(fwd_b)
    );
    assign ex_b = r.use_imm ? r.imm : fwd_b;
    assign ex_valid = r.valid;
    assign ex_op = r.alu_op;
    assign ex_rd = r.rd;
    assign ex_reg_we = r.reg_we;
    assign ex_mem_read = r.mem_read;
endmodule

// File: tb/tb_idex_stage.sv
// tb_idex_stage: random and directed checks of idex_stage against an instruction-level model
module tb_idex_stage;
    logic        clk = 0, rst = 1, stall, flush;
    logic        id_valid, id_uses_rs2, id_use_imm, id_reg_we, id_mem_read;
    logic [4:0]  id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, mem_res, wb_res;
    logic [3:0]  id_alu_op;
    logic        mem_reg_we, wb_reg_we;
    logic        id_ready, ex_valid, ex_reg_we, ex_mem_read;
    logic [31:0] ex_a, ex_b;
    logic [3:0]  ex_op;
    logic [4:0]  ex_rd;
    int n_vec = 0, n_bad = 0;

    idex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_alu_op(id_alu_op), .id_rd(id_rd),
        .id_reg_we(id_reg_we), .id_mem_read(id_mem_read),
        .mem_rd(mem_rd), .mem_reg_we(mem_reg_we), .mem_res(mem_res),
        .wb_rd(wb_rd), .wb_reg_we(wb_reg_we), .wb_res(wb_res),
        .id_ready(id_ready), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
        .ex_op(ex_op), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_mem_read(ex_mem_read)
    );

    always #5 clk = ~clk;

    // Model: the instruction currently sitting in EX, as decode described it.
    logic        m_valid, m_use_imm, m_we, m_mr;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_d1, m_d2, m_imm;
    logic [3:0]  m_op;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] newest(input logic [4:0] rs, input logic [31:0] rf);
        if (rs != 0 && mem_reg_we && mem_rd == rs) return mem_res;
        if (rs != 0 && wb_reg_we && wb_rd == rs) return wb_res;
        return rf;
    endfunction

    function automatic logic load_use();
        return id_valid && m_valid && m_mr && m_rd != 0 &&
               (m_rd == id_rs1 || (id_uses_rs2 && m_rd == id_rs2));
    endfunction

    task automatic model_reset();
        {m_valid, m_use_imm, m_we, m_mr, m_rs1, m_rs2, m_rd, m_d1, m_d2, m_imm, m_op} = '0;
    endtask

    task automatic model_take(input logic keep);
        m_valid = keep && id_valid; m_we = keep && id_reg_we; m_mr = keep && id_mem_read;
        m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_d1 = id_rs1_data; m_d2 = id_rs2_data;
        m_imm = id_imm; m_use_imm = id_use_imm; m_op = id_alu_op;
    endtask

    task automatic check_ready();
        #1 chk("id_ready", 32'(id_ready), 32'(!stall && !load_use()));
    endtask

    task automatic check_out();
        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("ex_reg_we", 32'(ex_reg_we), 32'(m_we));
        chk("ex_mem_read", 32'(ex_mem_read), 32'(m_mr));
        if (m_valid) begin
            chk("ex_rd", 32'(ex_rd), 32'(m_rd));
            chk("ex_op", 32'(ex_op), 32'(m_op));
            chk("ex_a", ex_a, newest(m_rs1, m_d1));
            chk("ex_b", ex_b, m_use_imm ? m_imm : newest(m_rs2, m_d2));
        end
    endtask

    // One clock: model follows flush > stall > hazard > normal, then outputs are compared.
    task automatic step();
        logic hz;
        hz = load_use();
        @(posedge clk);
        if (flush) model_take(1'b0);
        else if (!stall) model_take(!hz);
        #1 check_out();
        @(negedge clk);
    endtask

    task automatic idle();
        {stall, flush, id_valid, id_uses_rs2, id_use_imm, id_reg_we, id_mem_read} = '0;
        {id_rs1, id_rs2, id_rd, mem_rd, wb_rd, mem_reg_we, wb_reg_we} = '0;
        {id_rs1_data, id_rs2_data, id_imm, mem_res, wb_res} = '0;
        id_alu_op = 0;
    endtask

    task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] imm, input logic ui,
                         input logic [3:0] op, input logic [4:0] rd, input logic mr);
        id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rs1_data = d1; id_rs2_data = d2;
        id_imm = imm; id_use_imm = ui; id_alu_op = op; id_rd = rd; id_reg_we = 1;
        id_mem_read = mr; id_uses_rs2 = !ui;
    endtask

    initial begin
        idle();
        model_reset();
        #2;
        chk("rst ex_valid", 32'(ex_valid), 0);
        chk("rst ex_op", 32'(ex_op), 0);
        chk("rst ex_rd", 32'(ex_rd), 0);
        chk("rst id_ready", 32'(id_ready), 1);
        @(negedge clk) rst = 0;
        // AND with immediate zero
        instr(5'd1, 5'd2, 32'hFFFFFFFF, 32'h1234, 32'h0, 1, 4'd2, 5'd9, 0);
        check_ready();
        step();
        chk("and ex_a", ex_a, 32'hFFFFFFFF);
        chk("and ex_b", ex_b, 32'h0);
        chk("and res", ex_a & ex_b, 32'h0);
        // async reset with no clock edge
        #2 rst = 1;
        #1;
        chk("async ex_valid", 32'(ex_valid), 0);
        chk("async ex_op", 32'(ex_op), 0);
        chk("async ex_reg_we", 32'(ex_reg_we), 0);
        model_reset();
        @(negedge clk) rst = 0;
        // EX/MEM beats MEM/WB; index 0 never forwards
        idle();
        instr(5'd5, 5'd0, 32'h11111111, 32'h0, 32'h0, 1, 4'd0, 5'd1, 0);
        mem_rd = 5; mem_reg_we = 1; mem_res = 32'h7FFFFFFF;
        wb_rd = 5; wb_reg_we = 1; wb_res = 32'h1;
        step();
        chk("fwd mem wins", ex_a, 32'h7FFFFFFF);
        instr(5'd0, 5'd0, 32'h12345678, 32'h0, 32'h0, 1, 4'd0, 5'd1, 0);
        mem_rd = 0; wb_rd = 0;
        step();
        chk("fwd r0", ex_a, 32'h12345678);
        // load-use hazard
        idle();
        instr(5'd1, 5'd2, 32'h0, 32'h0, 32'h40, 1, 4'd0, 5'd3, 1);
        step();
        instr(5'd3, 5'd4, 32'hAA, 32'h0, 32'h0, 0, 4'd0, 5'd7, 0);
        #1 chk("hazard ready", 32'(id_ready), 0);
        step();
        chk("hazard bubble", 32'(ex_valid), 0);
        #1 chk("after bubble ready", 32'(id_ready), 1);
        step();
        chk("after bubble valid", 32'(ex_valid), 1);
        chk("after bubble rd", 32'(ex_rd), 7);
        // stall for 3 cycles, then stall with flush
        stall = 1;
        instr(5'd8, 5'd9, 32'h5, 32'h6, 32'h7, 1, 4'd3, 5'd12, 0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall ready", 32'(id_ready), 0);
            step();
            chk("stall ex_rd", 32'(ex_rd), 7);
        end
        flush = 1;
        step();
        chk("stall+flush", 32'(ex_valid), 0);
        // SLL with rs2 from MEM/WB
        idle();
        instr(5'd1, 5'd4, 32'h0000000F, 32'h0, 32'h0, 0, 4'd5, 5'd2, 0);
        wb_rd = 4; wb_reg_we = 1; wb_res = 32'd31;
        step();
        chk("sll ex_b", ex_b, 32'd31);
        chk("sll res", ex_a << ex_b[4:0], 32'h80000000);
        // randomized run
        for (int i = 0; i < 3000; i++) begin
            stall = ($urandom_range(7) == 0);
            flush = ($urandom_range(9) == 0);
            id_valid = ($urandom_range(3) != 0);
            id_rs1 = 5'($urandom_range(3));
            id_rs2 = 5'($urandom_range(3));
            id_rd = 5'($urandom_range(3));
            id_uses_rs2 = 1'($urandom);
            id_use_imm = 1'($urandom);
            id_reg_we = 1'($urandom);
            id_mem_read = ($urandom_range(2) == 0);
            id_alu_op = 4'($urandom_range(6));
            id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
            mem_rd = 5'($urandom_range(3)); mem_reg_we = 1'($urandom); mem_res = $urandom;
            wb_rd = 5'($urandom_range(3)); wb_reg_we = 1'($urandom); wb_res = $urandom;
            check_ready();
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
